fft_stage_sequencer: RTL and testbench

Control FSM and address generator for the in-place radix-2 DIT FFT engine, for runtime sizes N ∈ {2,4,8,16,32}. It issues one butterfly request per accepted handshake: sample-memory addresses plus the (k, n) pair for the twiddle ROM. A stage barrier holds each stage until all of its butterfly writebacks have returned. It sits between the top-level FFT control and the butterfly/twiddle-ROM datapath; sample memory is preloaded in bit-reversed order by the loader.

---
 rtl/fft_pkg.sv | 34 +++
 rtl/fft_stage_sequencer_if.sv | 32 +++
 rtl/fft_bfly_addr_gen.sv | 29 ++
 rtl/fft_stage_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and size helpers for the radix-2 FFT
// stage sequencer and its address generator.
package fft_pkg;

  localparam int MAX_N      = 32;
  localparam int ADDR_WIDTH = $clog2(MAX_N);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_WB
  } state_e;

  // Supported sizes are the powers of two from 2 up to MAX_N.
  function automatic logic is_valid_n(input logic [ADDR_WIDTH:0] n);
    return (n >= (ADDR_WIDTH+1)'(2)) &&
           (n <= (ADDR_WIDTH+1)'(MAX_N)) &&
           ((n & (n - 1'b1)) == '0);
  endfunction

  function automatic logic [2:0] log2_n(input logic [ADDR_WIDTH:0] n);
    logic [2:0] l;
    case (n)
      (ADDR_WIDTH+1)'(2):  l = 3'd1;
      (ADDR_WIDTH+1)'(4):  l = 3'd2;
      (ADDR_WIDTH+1)'(8):  l = 3'd3;
      (ADDR_WIDTH+1)'(16): l = 3'd4;
      (ADDR_WIDTH+1)'(32): l = 3'd5;
      default:             l = 3'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Control/butterfly-request bundle between the FFT top control, the
// butterfly datapath and the stage sequencer.
interface fft_stage_sequencer_if;
  import fft_pkg::*;

  logic                  start;
  logic [ADDR_WIDTH:0]   n;
  logic                  busy;
  logic                  err;
  logic                  bfly_valid;
  logic                  bfly_ready;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [ADDR_WIDTH-1:0] tw_k;
  logic [ADDR_WIDTH:0]   tw_n;
  logic [2:0]            stage;
  logic                  wb_valid;
  logic                  done;

  // Environment side: top control plus butterfly datapath.
  modport master (
    output start, n, bfly_ready, wb_valid,
    input  busy, err, bfly_valid, addr_a, addr_b, tw_k, tw_n, stage, done
  );

  // Sequencer side.
  modport slave (
    input  start, n, bfly_ready, wb_valid,
    output busy, err, bfly_valid, addr_a, addr_b, tw_k, tw_n, stage, done
  );

endinterface

// File: rtl/fft_bfly_addr_gen.sv
// Combinational butterfly address / twiddle generator: inserts a 0 at bit s
// of the butterfly counter to form the upper-leg address.
module fft_bfly_addr_gen
  import fft_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] cnt_i,
  input  logic [2:0]            s_i,
  output logic [ADDR_WIDTH-1:0] addr_a_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  output logic [ADDR_WIDTH-1:0] tw_k_o,
  output logic [ADDR_WIDTH:0]   tw_n_o
);

  logic [ADDR_WIDTH-1:0] m;
  logic [ADDR_WIDTH-1:0] mask;
  logic [ADDR_WIDTH-1:0] upper;
  logic [ADDR_WIDTH-1:0] addr_a;

  assign m     = ADDR_WIDTH'(1) << s_i;
  assign mask  = m - 1'b1;
  assign upper = (cnt_i >> s_i) << (s_i + 3'd1);
  assign addr_a = upper | (cnt_i & mask);

  assign addr_a_o = addr_a;
  assign addr_b_o = addr_a | m;
  assign tw_k_o   = cnt_i & mask;
  assign tw_n_o   = {m, 1'b0};

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for the in-place radix-2 DIT FFT: issues one
// butterfly request per handshake and holds each stage until writebacks drain.
module fft_stage_sequencer
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fft_stage_sequencer_if.slave bus
);

  state_e                state_q;
  logic [ADDR_WIDTH:0]   n_q;
  logic [2:0]            last_stage_q;
  logic [2:0]            stage_q;
  logic [2:0]            stage_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic [ADDR_WIDTH-1:0] outst_q;
  logic [ADDR_WIDTH-1:0] outst_d;

  logic                  busy_q;
  logic                  err_q;
  logic                  valid_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] addr_a_q;
  logic [ADDR_WIDTH-1:0] addr_b_q;
  logic [ADDR_WIDTH-1:0] tw_k_q;
  logic [ADDR_WIDTH:0]   tw_n_q;

  logic [ADDR_WIDTH-1:0] gen_a;
  logic [ADDR_WIDTH-1:0] gen_b;
  logic [ADDR_WIDTH-1:0] gen_k;
  logic [ADDR_WIDTH:0]   gen_n;

  logic accept;
  logic wb_take;
  logic last_cnt;

  assign accept   = valid_q && bus.bfly_ready;
  assign wb_take  = bus.wb_valid && (outst_q != '0);
  assign last_cnt = (cnt_q == ADDR_WIDTH'((n_q >> 1) - 1'b1));

  // Generator is fed the (cnt, s) of the request that will be loaded next.
  always_comb begin
    cnt_d   = cnt_q;
    stage_d = stage_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        stage_d = 3'd0;
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
      end
      WAIT_WB: begin
        cnt_d   = '0;
        stage_d = stage_q + 3'd1;
      end
      default: begin
        cnt_d   = '0;
        stage_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    case ({accept, wb_take})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  fft_bfly_addr_gen u_addr_gen (
    .cnt_i    (cnt_d),
    .s_i      (stage_d),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tw_k_o   (gen_k),
    .tw_n_o   (gen_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q <= '0;
    end else begin
      outst_q <= outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      last_stage_q <= 3'd0;
      stage_q      <= 3'd0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      tw_k_q       <= '0;
      tw_n_q       <= '0;
    end else begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (is_valid_n(bus.n)) begin
              n_q          <= bus.n;
              last_stage_q <= log2_n(bus.n) - 3'd1;
              stage_q      <= stage_d;
              cnt_q        <= cnt_d;
              busy_q       <= 1'b1;
              valid_q      <= 1'b1;
              addr_a_q     <= gen_a;
              addr_b_q     <= gen_b;
              tw_k_q       <= gen_k;
              tw_n_q       <= gen_n;
              state_q      <= ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Request registers only move on acceptance, so a stall holds them.
          if (accept) begin
            cnt_q <= cnt_d;
            if (last_cnt) begin
              valid_q <= 1'b0;
              state_q <= WAIT_WB;
            end else begin
              addr_a_q <= gen_a;
              addr_b_q <= gen_b;
              tw_k_q   <= gen_k;
              tw_n_q   <= gen_n;
            end
          end
        end
        WAIT_WB: begin
          if (outst_q == '0) begin
            if (stage_q != last_stage_q) begin
              stage_q  <= stage_d;
              cnt_q    <= cnt_d;
              valid_q  <= 1'b1;
              addr_a_q <= gen_a;
              addr_b_q <= gen_b;
              tw_k_q   <= gen_k;
              tw_n_q   <= gen_n;
              state_q  <= ISSUE;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.bfly_valid = valid_q;
  assign bus.done       = done_q;
  assign bus.addr_a     = addr_a_q;
  assign bus.addr_b     = addr_b_q;
  assign bus.tw_k       = tw_k_q;
  assign bus.tw_n       = tw_n_q;
  assign bus.stage      = stage_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: request ordering, stage barrier,
// stall stability, error pulses, reset abort and start-while-busy immunity.
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  typedef logic [23:0] req_t;  // {stage, addr_a, addr_b, tw_k, tw_n}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_stage_sequencer_if bif ();

  fft_stage_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int   checks = 0;
  int   errors = 0;
  req_t log_q[$];
  req_t exp_q[$];
  int   done_cnt, err_cnt, done_cyc, stall_viol, barrier_viol, busy_drop;
  bit   timeout, busy_at_done;

  function automatic req_t pack(int s, int a, int b, int k, int tn);
    return {3'(s), 5'(a), 5'(b), 5'(k), 6'(tn)};
  endfunction

  task automatic build_expected(input int nn);
    int s;
    exp_q.delete();
    s = 0;
    for (int m = 1; m < nn; m = m * 2) begin
      for (int g = 0; g < nn; g = g + 2 * m)
        for (int k = 0; k < m; k++)
          exp_q.push_back(pack(s, g + k, g + k + m, k, 2 * m));
      s++;
    end
  endtask

  task automatic build_n8_table;
    exp_q.delete();
    exp_q.push_back(pack(0, 0, 1, 0, 2)); exp_q.push_back(pack(0, 2, 3, 0, 2));
    exp_q.push_back(pack(0, 4, 5, 0, 2)); exp_q.push_back(pack(0, 6, 7, 0, 2));
    exp_q.push_back(pack(1, 0, 2, 0, 4)); exp_q.push_back(pack(1, 1, 3, 1, 4));
    exp_q.push_back(pack(1, 4, 6, 0, 4)); exp_q.push_back(pack(1, 5, 7, 1, 4));
    exp_q.push_back(pack(2, 0, 4, 0, 8)); exp_q.push_back(pack(2, 1, 5, 1, 8));
    exp_q.push_back(pack(2, 2, 6, 2, 8)); exp_q.push_back(pack(2, 3, 7, 3, 8));
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bif.start = 1'b0; bif.n = '0; bif.bfly_ready = 1'b0; bif.wb_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drives one transform from the current (posedge+1) point and records
  // every accepted request plus protocol observations.
  task automatic run(input int nn, input bit rnd, input int maxdly,
                     input bit perturb, input int budget);
    int   due_q[$];
    req_t prev_req, cur;
    bit   prev_valid, prev_ready, prev_wb;
    int   accepts, sampled, last_stage, cyc;
    log_q.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -1; stall_viol = 0;
    barrier_viol = 0; busy_drop = 0; timeout = 0; busy_at_done = 1'b1;
    bif.start = 1'b1; bif.n = 6'(nn); bif.wb_valid = 1'b0;
    bif.bfly_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    prev_valid = 1'b0; prev_ready = bif.bfly_ready; prev_wb = 1'b0;
    prev_req = '0; accepts = 0; sampled = 0; last_stage = 0; cyc = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      bif.start = 1'b0;
      cur = {bif.stage, bif.addr_a, bif.addr_b, bif.tw_k, bif.tw_n};
      if (prev_wb) sampled++;
      if (prev_valid && prev_ready) begin
        if (int'(prev_req[23:21]) != last_stage && accepts != sampled) barrier_viol++;
        last_stage = int'(prev_req[23:21]);
        log_q.push_back(prev_req);
        accepts++;
        due_q.push_back(cyc + ((maxdly > 0) ? int'($urandom_range(0, maxdly)) : 0));
      end
      if (prev_valid && !prev_ready)
        if (!bif.bfly_valid || cur != prev_req) stall_viol++;
      if (bif.err) err_cnt++;
      if (bif.done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = bif.busy;
        break;
      end
      if (!bif.busy) busy_drop++;
      if (cyc >= budget) begin
        timeout = 1'b1;
        break;
      end
      prev_wb = 1'b0;
      bif.wb_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        bif.wb_valid = 1'b1;
        prev_wb = 1'b1;
      end
      bif.bfly_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      prev_ready = bif.bfly_ready;
      prev_valid = bif.bfly_valid;
      prev_req   = cur;
      if (perturb && (cyc == 3 || cyc == 10)) begin
        bif.start = 1'b1;
        bif.n = 6'd32;
      end
    end
    bif.wb_valid = 1'b0;
    bif.bfly_ready = 1'b0;
    bif.start = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({bif.busy, bif.err, bif.bfly_valid, bif.done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000", {bif.busy, bif.err, bif.bfly_valid, bif.done});
    end
    checks++;
    if ({bif.addr_a, bif.addr_b, bif.tw_k} !== 15'd0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0", {bif.addr_a, bif.addr_b, bif.tw_k});
    end
    checks++;
    if ({bif.tw_n, bif.stage} !== 9'd0) begin
      errors++;
      $display("FAIL reset_tw_stage got %h want 0", {bif.tw_n, bif.stage});
    end
    $display("test_reset done");
  endtask

  task automatic test_n2;
    do_reset;
    run(2, 1'b0, 0, 1'b0, 50);
    checks++;
    if (log_q.size() !== 1 || log_q[0] !== pack(0, 0, 1, 0, 2)) begin
      errors++;
      $display("FAIL n2_req got size %0d first %h want size 1 %h", log_q.size(),
               (log_q.size() > 0) ? log_q[0] : 24'h0, pack(0, 0, 1, 0, 2));
    end
    checks++;
    if (done_cyc !== 4 || timeout) begin
      errors++;
      $display("FAIL n2_done_cycle got %0d want 4", done_cyc);
    end
    checks++;
    if (err_cnt !== 0 || busy_drop !== 0 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL n2_flags got err %0d busy_drop %0d busy_at_done %b want 0 0 0",
               err_cnt, busy_drop, busy_at_done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bif.done !== 1'b0 || bif.busy !== 1'b0) begin
      errors++;
      $display("FAIL n2_done_pulse got done %b busy %b want 0 0", bif.done, bif.busy);
    end
    $display("test_n2 done: %0d requests, done at cycle %0d", log_q.size(), done_cyc);
  endtask

  task automatic test_n8;
    do_reset;
    run(8, 1'b0, 0, 1'b0, 100);
    build_n8_table;
    checks++;
    if (log_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL n8_count got %0d want %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL n8_req[%0d] got %h want %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cyc !== 19 || done_cnt !== 1) begin
      errors++;
      $display("FAIL n8_done got cycle %0d count %0d want 19 1", done_cyc, done_cnt);
    end
    $display("test_n8 done: %0d requests, done at cycle %0d", log_q.size(), done_cyc);
  endtask

  task automatic test_n32_random;
    do_reset;
    run(32, 1'b1, 5, 1'b0, 5000);
    build_expected(32);
    checks++;
    if (log_q.size() !== 80 || timeout) begin
      errors++;
      $display("FAIL n32_count got %0d (timeout %b) want 80", log_q.size(), timeout);
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL n32_req[%0d] got %h want %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++;
      $display("FAIL n32_stall got %0d violations want 0", stall_viol);
    end
    checks++;
    if (barrier_viol !== 0) begin
      errors++;
      $display("FAIL n32_barrier got %0d violations want 0", barrier_viol);
    end
    checks++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      errors++;
      $display("FAIL n32_done got done %0d err %0d want 1 0", done_cnt, err_cnt);
    end
    $display("test_n32_random done: %0d requests, done at cycle %0d", log_q.size(), done_cyc);
  endtask

  task automatic test_err;
    logic [5:0] bad [6];
    bad = '{6'd12, 6'd0, 6'd33, 6'd63, 6'd1, 6'd3};
    do_reset;
    for (int i = 0; i < 6; i++) begin
      bif.start = 1'b1;
      bif.n = bad[i];
      @(posedge clk);
      #1;
      bif.start = 1'b0;
      checks++;
      if ({bif.err, bif.busy, bif.bfly_valid} !== 3'b100) begin
        errors++;
        $display("FAIL err_pulse n=%0d got err/busy/valid %b want 100", bad[i],
                 {bif.err, bif.busy, bif.bfly_valid});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bif.err, bif.busy, bif.bfly_valid} !== 3'b000) begin
        errors++;
        $display("FAIL err_clear n=%0d got err/busy/valid %b want 000", bad[i],
                 {bif.err, bif.busy, bif.bfly_valid});
      end
      $display("test_err n=%0d checked", bad[i]);
    end
  endtask

  task automatic test_reset_mid;
    bit seen, pv;
    do_reset;
    bif.start = 1'b1; bif.n = 6'd16; bif.bfly_ready = 1'b1; bif.wb_valid = 1'b0;
    seen = 1'b0; pv = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge clk);
      #1;
      bif.start = 1'b0;
      bif.wb_valid = pv;
      pv = bif.bfly_valid;
      if (bif.stage == 3'd2 && bif.bfly_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstmid_reach_stage2 got 0 want 1");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bif.busy, bif.err, bif.bfly_valid, bif.done, bif.addr_a, bif.addr_b,
         bif.tw_k, bif.tw_n, bif.stage} !== 28'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got %h want 0", {bif.busy, bif.err, bif.bfly_valid,
               bif.done, bif.addr_a, bif.addr_b, bif.tw_k, bif.tw_n, bif.stage});
    end
    bif.wb_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bif.wb_valid = 1'b0;
    bif.bfly_ready = 1'b0;
    run(4, 1'b0, 0, 1'b0, 50);
    build_expected(4);
    checks++;
    if (log_q.size() !== 4) begin
      errors++;
      $display("FAIL rstmid_n4_count got %0d want 4", log_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rstmid_n4_req[%0d] got %h want %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cyc !== 9) begin
      errors++;
      $display("FAIL rstmid_n4_done got %0d want 9", done_cyc);
    end
    $display("test_reset_mid done: n=4 rerun done at cycle %0d", done_cyc);
  endtask

  task automatic test_ignore_start;
    do_reset;
    run(8, 1'b0, 0, 1'b1, 100);
    build_n8_table;
    checks++;
    if (log_q.size() !== 12) begin
      errors++;
      $display("FAIL ign_count got %0d want 12", log_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ign_req[%0d] got %h want %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cyc !== 19 || err_cnt !== 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL ign_done got cycle %0d err %0d done %0d want 19 0 1",
               done_cyc, err_cnt, done_cnt);
    end
    $display("test_ignore_start done: done at cycle %0d", done_cyc);
  endtask

  task automatic test_back_to_back;
    do_reset;
    run(2, 1'b0, 0, 1'b0, 50);
    // Next start is driven during the done cycle.
    run(4, 1'b0, 0, 1'b0, 50);
    build_expected(4);
    checks++;
    if (log_q.size() !== 4 || done_cyc !== 9) begin
      errors++;
      $display("FAIL b2b_n4 got count %0d cycle %0d want 4 9", log_q.size(), done_cyc);
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_req[%0d] got %h want %h", i, log_q[i], exp_q[i]);
      end
    end
    $display("test_back_to_back done: done at cycle %0d", done_cyc);
  endtask

  initial begin
    test_reset;
    test_n2;
    test_n8;
    test_n32_random;
    test_err;
    test_reset_mid;
    test_ignore_start;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
